link_arq_ctrl: RTL

LINK_ARQ_CTRL -- requirements
Module: link_arq_ctrl

---
 rtl/link_pkg.sv | 22 ++
 rtl/link_arq_ctrl_if.sv | 49 ++++
 rtl/timeout_counter.sv | 40 ++++
 rtl/link_arq_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared types and default parameters for the ARQ link controller.
package link_pkg;

    localparam int N_PKT_DEF     = 8;
    localparam int TIMEOUT_DEF   = 1540;
    localparam int MAX_RETRY_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_TX_BUSY = 3'd2,
        ST_LISTEN  = 3'd3,
        ST_DONE    = 3'd4,
        ST_FAIL    = 3'd5
    } state_t;

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/link_arq_ctrl_if.sv
// Bundle of user, encoder and decoder signals around the ARQ controller.
// Handshakes: a user request transfers on a cycle where tx_valid && tx_ready;
// a decoder word transfers on a cycle where dec_avail && dec_read; enc_start,
// dec_read, rx_valid, done and fail are single-cycle pulses.
interface link_arq_ctrl_if #(
    parameter int N_PKT = link_pkg::N_PKT_DEF
);
    import link_pkg::*;

    logic             tx_valid;
    logic [N_PKT-1:0] tx_data;
    logic [N_PKT-1:0] exp_data;
    logic             tx_ready;

    logic             enc_start;
    logic [N_PKT-1:0] enc_data;
    logic             enc_avail;

    logic [N_PKT-1:0] dec_data;
    logic             dec_avail;
    logic             dec_error;
    logic             dec_read;

    logic [N_PKT-1:0] rx_data;
    logic             rx_valid;
    logic             done;
    logic             fail;
    logic             busy;
    logic [1:0]       retry_cnt;
    logic [15:0]      ok_cnt;
    logic [15:0]      fail_cnt;

    state_t           state_dbg;

    // Controller side.
    modport master (
        input  tx_valid, tx_data, exp_data, enc_avail, dec_data, dec_avail, dec_error,
        output tx_ready, enc_start, enc_data, dec_read, rx_data, rx_valid,
               done, fail, busy, retry_cnt, ok_cnt, fail_cnt, state_dbg
    );

    // Environment side (user, encoder, decoder).
    modport slave (
        output tx_valid, tx_data, exp_data, enc_avail, dec_data, dec_avail, dec_error,
        input  tx_ready, enc_start, enc_data, dec_read, rx_data, rx_valid,
               done, fail, busy, retry_cnt, ok_cnt, fail_cnt, state_dbg
    );

endinterface

// File: rtl/timeout_counter.sv
// Response-wait timer: clears to zero, counts while enabled, saturates at
// its maximum and flags the last allowed cycle (TIMEOUT-1).
module timeout_counter #(
    parameter int TIMEOUT = link_pkg::TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] CNT_MAX  = '1;
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Next count: clear wins, otherwise increment without wrapping.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == CNT_LAST);

endmodule

// File: rtl/link_arq_ctrl.sv
// Stop-and-wait ARQ controller: sends one packet through the encoder, waits
// for the matching reply from the decoder, and retransmits on error,
// mismatch or timeout until the retry budget is spent.
module link_arq_ctrl
    import link_pkg::*;
#(
    parameter int N_PKT     = N_PKT_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic            clk,
    input  logic            rst,
    link_arq_ctrl_if.master bus
);
    localparam logic [1:0] RETRY_LAST = 2'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [1:0]       retry_q, retry_d;
    logic [N_PKT-1:0] tx_lat_q, tx_lat_d;
    logic [N_PKT-1:0] exp_lat_q, exp_lat_d;
    logic [N_PKT-1:0] rx_data_q, rx_data_d;
    logic [15:0]      ok_cnt_q, ok_cnt_d;
    logic [15:0]      fail_cnt_q, fail_cnt_d;
    logic             enc_start_q, enc_start_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic             busy_q, busy_d;

    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expired;
    logic miss;

    timeout_counter #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        tx_lat_d   = tx_lat_q;
        exp_lat_d  = exp_lat_q;
        rx_data_d  = rx_data_q;
        ok_cnt_d   = ok_cnt_q;
        fail_cnt_d = fail_cnt_q;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;
        miss       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.tx_valid && bus.enc_avail) begin
                    tx_lat_d  = bus.tx_data;
                    exp_lat_d = bus.exp_data;
                    retry_d   = 2'd0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_TX_BUSY;
            end
            ST_TX_BUSY: begin
                // Hold the timer at zero so LISTEN starts counting from 0.
                tmr_clear = 1'b1;
                if (bus.enc_avail) begin
                    state_d = ST_LISTEN;
                end
            end
            ST_LISTEN: begin
                tmr_enable = 1'b1;
                // A decoder word on the last timer cycle beats the timeout.
                if (bus.dec_avail) begin
                    if (!bus.dec_error && (bus.dec_data == exp_lat_q)) begin
                        rx_data_d = bus.dec_data;
                        ok_cnt_d  = sat_inc16(ok_cnt_q);
                        state_d   = ST_DONE;
                    end else begin
                        miss = 1'b1;
                    end
                end else if (tmr_expired) begin
                    miss = 1'b1;
                end
                if (miss) begin
                    if (retry_q == RETRY_LAST) begin
                        fail_cnt_d = sat_inc16(fail_cnt_q);
                        state_d    = ST_FAIL;
                    end else begin
                        retry_d = retry_q + 2'd1;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAIL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        enc_start_d = (state_d == ST_SEND);
        done_d      = (state_d == ST_DONE);
        fail_d      = (state_d == ST_FAIL);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, datapath and output registers; reset returns to IDLE at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            retry_q     <= 2'd0;
            tx_lat_q    <= '0;
            exp_lat_q   <= '0;
            rx_data_q   <= '0;
            ok_cnt_q    <= 16'd0;
            fail_cnt_q  <= 16'd0;
            enc_start_q <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            retry_q     <= retry_d;
            tx_lat_q    <= tx_lat_d;
            exp_lat_q   <= exp_lat_d;
            rx_data_q   <= rx_data_d;
            ok_cnt_q    <= ok_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            enc_start_q <= enc_start_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            busy_q      <= busy_d;
        end
    end

    // Decoder words are consumed in every waiting state; outside LISTEN they
    // are stale and simply dropped.
    assign bus.dec_read  = !rst && bus.dec_avail &&
                           ((state_q == ST_IDLE) || (state_q == ST_SEND) ||
                            (state_q == ST_TX_BUSY) || (state_q == ST_LISTEN));
    assign bus.tx_ready  = !rst && (state_q == ST_IDLE) && bus.enc_avail;

    assign bus.enc_start = enc_start_q;
    assign bus.enc_data  = tx_lat_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = done_q;
    assign bus.done      = done_q;
    assign bus.fail      = fail_q;
    assign bus.busy      = busy_q;
    assign bus.retry_cnt = retry_q;
    assign bus.ok_cnt    = ok_cnt_q;
    assign bus.fail_cnt  = fail_cnt_q;
    assign bus.state_dbg = state_q;

endmodule
